// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC control, imem handshake, redirect resolution
// Optional FETCH_ADDR_ERR_EN: misaligned fetch addresses trap to decode with if_adel instead of being issued.
module fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc00000,
  parameter logic [WIDTH-1:0] EXC_VEC  = 32'hbfc00380
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_q,
  output logic             pc_en,
  output logic [WIDTH-1:0] pc_d,
  output logic             pc_flush,
  output logic [WIDTH-1:0] pc_newpc,
  input  logic             exc_i,
  input  logic             eret_i,
  input  logic [WIDTH-1:0] epc_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             stall_i,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_inst,
  output logic             if_adel
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] req_addr, req_addr_next;
  logic [WIDTH-1:0] redir_addr, redir_addr_next;
  logic [WIDTH-1:0] hold_pc, hold_pc_next;
  logic [WIDTH-1:0] hold_inst, hold_inst_next;
  logic             cancel, cancel_next;
  logic             redir;
  logic [WIDTH-1:0] tgt;
`ifdef FETCH_ADDR_ERR_EN
  logic             adel, adel_next;
`endif

  always_comb begin
    redir = exc_i | eret_i | branch_i;
    if (exc_i)       tgt = EXC_VEC;
    else if (eret_i) tgt = epc_i;
    else             tgt = branch_target_i;
  end

  assign pc_flush  = redir;
  assign pc_newpc  = tgt;
  assign pc_d      = pc_q + WIDTH'(4);
  assign inst_req  = (state == S_REQ);
  assign inst_addr = req_addr;
  assign if_valid  = (state == S_HOLD);
  assign if_pc     = hold_pc;
  assign if_inst   = hold_inst;

  always_comb begin
    state_next      = state;
    req_addr_next   = req_addr;
    redir_addr_next = redir_addr;
    cancel_next     = cancel;
    hold_pc_next    = hold_pc;
    hold_inst_next  = hold_inst;
    pc_en           = 1'b0;
    case (state)
      S_IDLE: begin
        state_next    = S_REQ;
        req_addr_next = redir ? tgt : pc_q;
      end
      S_REQ: begin
        // The request is never withdrawn; a redirect only marks its response stale.
        if (redir) begin
          cancel_next     = 1'b1;
          redir_addr_next = tgt;
        end
        if (inst_addr_ok) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (redir) begin
          cancel_next     = 1'b1;
          redir_addr_next = tgt;
        end
        if (inst_data_ok) begin
          if (cancel || redir) begin
            cancel_next   = 1'b0;
            req_addr_next = redir ? tgt : redir_addr;
            state_next    = S_REQ;
          end else begin
            hold_inst_next = inst_rdata;
            hold_pc_next   = req_addr;
            state_next     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redir) begin
          req_addr_next = tgt;
          state_next    = S_REQ;
        end else if (!stall_i) begin
          pc_en         = 1'b1;
          req_addr_next = pc_d;
          state_next    = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
`ifdef FETCH_ADDR_ERR_EN
    adel_next = adel && (state_next == S_HOLD);
    // A misaligned fetch never reaches the bus; it is handed to decode as a faulting slot.
    if (state_next == S_REQ && state != S_REQ && req_addr_next[1:0] != 2'b00) begin
      state_next     = S_HOLD;
      hold_inst_next = '0;
      hold_pc_next   = req_addr_next;
      adel_next      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_addr   <= RESET_PC;
      redir_addr <= RESET_PC;
      hold_pc    <= RESET_PC;
      hold_inst  <= '0;
      cancel     <= 1'b0;
`ifdef FETCH_ADDR_ERR_EN
      adel       <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      req_addr   <= req_addr_next;
      redir_addr <= redir_addr_next;
      hold_pc    <= hold_pc_next;
      hold_inst  <= hold_inst_next;
      cancel     <= cancel_next;
`ifdef FETCH_ADDR_ERR_EN
      adel       <= adel_next;
`endif
    end
  end

`ifdef FETCH_ADDR_ERR_EN
  assign if_adel = adel;
`else
  assign if_adel = 1'b0;
`endif

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the MIPS core. It owns the PC register's `en`, `flush` and `newpc` controls and drives the SRAM-like instruction-memory request/response handshake. It hands fetched instructions to decode and resolves competing redirects (exception, eret, branch) against an in-flight fetch. It sits between the PC register, the hazard unit and the instruction bus interface.

## Interface
- `WIDTH`, 32, address/data width
- `RESET_PC`, 32'hbfc00000, boot address; must equal the PC register's reset value
- `EXC_VEC`, 32'hbfc00380, exception entry address
- `clk` in 1 system clock, rising edge
- `rst_n` in 1 asynchronous active-low reset
- `pc_q` in WIDTH current PC register value
- `pc_en` out 1 PC register enable; PC loads `pc_d`
- `pc_d` out WIDTH sequential next PC, `pc_q + 4`
- `pc_flush` out 1 PC register flush; PC loads `pc_newpc`
- `pc_newpc` out WIDTH redirect target
- `exc_i` in 1 exception redirect to `EXC_VEC`
- `eret_i` in 1 eret redirect to `epc_i`
- `epc_i` in WIDTH eret target
- `branch_i` in 1 taken branch/jump redirect
- `branch_target_i` in WIDTH branch target
- `stall_i` in 1 decode cannot accept an instruction this cycle
- `inst_req` out 1 instruction-memory request
- `inst_addr` out WIDTH request address
- `inst_addr_ok` in 1 request accepted
- `inst_data_ok` in 1 response data valid
- `inst_rdata` in WIDTH response data
- `if_valid` out 1 instruction presented to decode
- `if_pc` out WIDTH PC of the presented instruction
- `if_inst` out WIDTH presented instruction
- `if_adel` out 1 fetch address error flag for the presented instruction

## Operation
- The redirect priority is `exc_i` > `eret_i` > `branch_i`. `redir` is the OR of the three. `tgt` is the selected target.
- When `redir` is high, `pc_flush` is 1 and `pc_newpc` is `tgt` in the same cycle, combinationally.
- `pc_en` is never asserted in a cycle where `pc_flush` is asserted.
- Registers:
  - `req_addr`: drives `inst_addr`.
  - `cancel`: marks an outstanding fetch as stale.
  - `redir_addr`: the target saved for a cancelled fetch.
  - `hold_inst` and `hold_pc`: the instruction presented to decode.
- FSM states:
  - **S_IDLE** (reset state): `inst_req` is 0. Next state is S_REQ with `req_addr` ← `redir ? tgt : pc_q`.
  - **S_REQ**: `inst_req` is 1 and `inst_addr` is `req_addr`. The address stays stable until `inst_addr_ok`.
    - On `inst_addr_ok`, go to S_WAIT.
    - A `redir` in this state never withdraws the request. It sets `cancel` to 1 and `redir_addr` ← `tgt`, whether or not `inst_addr_ok` is high that cycle.
  - **S_WAIT**: `inst_req` is 0.
    - A `redir` sets `cancel` to 1 and `redir_addr` ← `tgt`.
    - On `inst_data_ok` with `cancel` (registered or set this cycle): the data is dropped, `cancel` ← 0, `req_addr` ← `redir_addr`, next state S_REQ.
    - On `inst_data_ok` without cancel: `hold_inst` ← `inst_rdata`, `hold_pc` ← `req_addr`, next state S_HOLD.
  - **S_HOLD**: `if_valid` is 1.
    - With `redir`: the held instruction is dropped, `req_addr` ← `tgt`, next state S_REQ.
    - Else, with `!stall_i`: decode consumes the instruction, `pc_en` is 1, `req_addr` ← `pc_q + 4`, next state S_REQ.
    - Else (stalled): remain in S_HOLD with outputs stable.
- A later redirect overwrites `redir_addr`, so the last redirect wins.
- `if_valid` is 1 only in S_HOLD. `if_pc` = `hold_pc` and `if_inst` = `hold_inst`.
- `pc_d` is always `pc_q + 4` and wraps modulo 2^WIDTH.

## Timing
- Reset values:
  - State is S_IDLE.
  - `inst_req`, `if_valid`, `if_adel`, `pc_en`, `cancel` are 0.
  - `req_addr`, `redir_addr`, `hold_pc` are `RESET_PC`.
  - `hold_inst` is 0.
  - `pc_flush` follows the redirect inputs combinationally.
- Reset asserted mid-transaction returns to S_IDLE immediately and abandons any outstanding response. The bus interface must be reset together with this block.
- `inst_data_ok` is ignored outside S_WAIT. Data returns at least one cycle after `inst_addr_ok`.
- Best-case throughput is 3 cycles per instruction: REQ (addr_ok) → WAIT (data_ok) → HOLD (consume).
- The first request after reset is in cycle 2: cycle 1 is S_IDLE, then S_REQ with `inst_addr` = `RESET_PC`.

## Configuration
- Macro `FETCH_ADDR_ERR_EN`.
- When defined:
  - Entering S_REQ with `req_addr[1:0]` ≠ 0 issues no request.
  - The FSM goes directly to S_HOLD with `hold_inst` = 0, `hold_pc` = `req_addr` and `if_adel` = 1.
  - `if_adel` is cleared on leaving S_HOLD.
- When undefined: `if_adel` is tied to 0 and every address is issued as-is.

## Test plan
- Reset release, memory answers with `addr_ok` on the first cycle and `data_ok` one cycle later → `inst_addr` = bfc00000. Then `if_valid` with `if_pc` = bfc00000, `pc_en` one cycle, and the next `inst_addr` = bfc00004.
- `stall_i` held high 5 cycles in S_HOLD → `if_inst` stable, `pc_en` = 0 and `inst_req` = 0 throughout. The next request is issued the cycle after the stall drops.
- `branch_i` with target bfc00100 during S_WAIT → `pc_flush` with `pc_newpc` = bfc00100, the returning data is dropped (`if_valid` stays 0), and the next `inst_addr` = bfc00100.
- `exc_i`, `eret_i` (epc 80000020) and `branch_i` asserted in the same cycle → `pc_newpc` = bfc00380 and the next fetch address is bfc00380.
- Redirect in S_REQ while `addr_ok` is withheld 3 cycles → `inst_addr` stays at the old address until accepted. The response is then discarded and the target is fetched.
- With `FETCH_ADDR_ERR_EN`, eret to 80000002 → no `inst_req`, and `if_valid` = 1 with `if_adel` = 1, `if_pc` = 80000002, `if_inst` = 0.
